// File: rtl/inflation_stream_sequencer.sv
// Frame sequencer in front of the map-inflation engine: gates the input stream into
// a weight phase and a row phase, counts result beats, generates TLAST and status flags.
module inflation_stream_sequencer #(
  parameter int KERNEL_SIZE   = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int ROW_CNT_WIDTH = 16,
  parameter int OUT_WIDTH     = (DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE) * KERNEL_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic [ROW_CNT_WIDTH-1:0] cfg_rows,
  output logic                     busy,
  output logic                     done,
  output logic                     err_tlast,
  output logic                     err_cfg,
  input  logic [BUS_WIDTH-1:0]     s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [BUS_WIDTH-1:0]     e_axis_tdata,
  output logic                     e_axis_tvalid,
  input  logic                     e_axis_tready,
  input  logic [OUT_WIDTH-1:0]     r_axis_tdata,
  input  logic                     r_axis_tvalid,
  output logic                     r_axis_tready,
  output logic [OUT_WIDTH-1:0]     m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast
);

  localparam int WBEATS = (KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int RBEATS = (KERNEL_SIZE * DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                   state_q;
  logic [ROW_CNT_WIDTH-1:0] rows_q;
  logic [31:0]              in_cnt_q;
  logic [31:0]              out_cnt_q;
  logic                     err_tlast_q;
  logic                     err_cfg_q;

  logic        in_en_s;
  logic        out_en_s;
  logic        in_beat_s;
  logic        out_beat_s;
  logic [31:0] rows32_s;
  logic [31:0] total_s;
  logic        in_last_s;
  logic        out_last_s;

  assign in_en_s    = (state_q == S_LOAD_W) || (state_q == S_STREAM);
  assign out_en_s   = in_en_s || (state_q == S_DRAIN);
  assign rows32_s   = 32'(rows_q);
  assign total_s    = 32'(WBEATS) + rows32_s * 32'(RBEATS);
  assign in_last_s  = (in_cnt_q == total_s - 32'd1);
  assign out_last_s = (out_cnt_q == rows32_s - 32'd1);

  // Pure pass-through: the sequencer never buffers, it only opens and closes the gates.
  assign e_axis_tdata  = s_axis_tdata;
  assign e_axis_tvalid = s_axis_tvalid & in_en_s;
  assign s_axis_tready = e_axis_tready & in_en_s;
  assign m_axis_tdata  = r_axis_tdata;
  assign m_axis_tvalid = r_axis_tvalid & out_en_s;
  assign r_axis_tready = m_axis_tready & out_en_s;
  assign m_axis_tlast  = m_axis_tvalid & out_last_s;

  assign in_beat_s  = s_axis_tvalid & s_axis_tready;
  assign out_beat_s = m_axis_tvalid & m_axis_tready;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err_tlast = err_tlast_q;
  assign err_cfg   = err_cfg_q;

  // Frame FSM with beat counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      in_cnt_q    <= 32'd0;
      out_cnt_q   <= 32'd0;
      err_tlast_q <= 1'b0;
      err_cfg_q   <= 1'b0;
    end else if (cfg_abort) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= 32'd0;
      out_cnt_q <= 32'd0;
    end else begin
      if (cfg_start && (cfg_rows != '0)) begin
        err_cfg_q <= 1'b0;
      end
      if (in_beat_s) begin
        in_cnt_q <= in_cnt_q + 32'd1;
        if (s_axis_tlast != in_last_s) begin
          err_tlast_q <= 1'b1;
        end
      end
      // Saturate at rows so an early final result still lets DRAIN exit.
      if (out_beat_s && (out_cnt_q != rows32_s)) begin
        out_cnt_q <= out_cnt_q + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_rows != '0) begin
              rows_q      <= cfg_rows;
              in_cnt_q    <= 32'd0;
              out_cnt_q   <= 32'd0;
              err_tlast_q <= 1'b0;
              state_q     <= S_LOAD_W;
            end else begin
              err_cfg_q <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (in_beat_s && (in_cnt_q == 32'(WBEATS) - 32'd1)) begin
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (in_beat_s && in_last_s) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((out_beat_s && out_last_s) || (out_cnt_q == rows32_s)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/inflation_stream_sequencer.md
Name: inflation_stream_sequencer

Overview:
- Frame-level controller in front of the map-inflation engine (weight loader, accumulator, PE, output FIFO).
- Gates the DMA input stream into a weight phase then a row-data phase, counts input beats and returned result beats, and generates TLAST toward the output DMA.
- Checks input framing and reports busy/done/error status to software.

Parameters:
KERNEL_SIZE, 3, kernel dimension (pixels per row, kernel is KxK)
DATA_WIDTH, 8, pixel width
WEIGHT_WIDTH, 8, weight width
BUS_WIDTH, 32, input AXI-Stream data width
ROW_CNT_WIDTH, 16, width of row-count configuration
OUT_WIDTH, (DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE)*KERNEL_SIZE, engine result width (57 at defaults)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_start  in  1  single-cycle frame start pulse
cfg_abort  in  1  single-cycle abort pulse
cfg_rows  in  ROW_CNT_WIDTH  rows in frame; sampled on accepted cfg_start
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse on frame completion
err_tlast  out  1  sticky input framing error
err_cfg  out  1  sticky: start with cfg_rows==0
s_axis_tdata  in  BUS_WIDTH  input from DMA
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input last
s_axis_tready  out  1  input ready
e_axis_tdata  out  BUS_WIDTH  to engine input
e_axis_tvalid  out  1  to engine
e_axis_tready  in  1  from engine
r_axis_tdata  in  OUT_WIDTH  engine result
r_axis_tvalid  in  1  engine result valid
r_axis_tready  out  1  result ready
m_axis_tdata  out  OUT_WIDTH  result to DMA
m_axis_tvalid  out  1  to DMA
m_axis_tready  in  1  from DMA
m_axis_tlast  out  1  final result of frame

Behaviour:
- Derived constants:
  - WBEATS = ceil(KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH/BUS_WIDTH), 3 at defaults.
  - RBEATS = ceil(KERNEL_SIZE*DATA_WIDTH/BUS_WIDTH), 1 at defaults.
  - Frame input beats TOTAL = WBEATS + rows*RBEATS. Internal counters are 32-bit.
- Reset: state IDLE, all counters 0, busy=0, done=0, err_tlast=0, err_cfg=0, s_axis_tready=0, e_axis_tvalid=0, r_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
- Data paths are zero-latency combinational pass-through, gated by state (no buffering):
  - in_en = state in {LOAD_W, STREAM}.
  - e_axis_tvalid = s_axis_tvalid & in_en; s_axis_tready = e_axis_tready & in_en; e_axis_tdata = s_axis_tdata.
  - out_en = state in {LOAD_W, STREAM, DRAIN}.
  - m_axis_tvalid = r_axis_tvalid & out_en; r_axis_tready = m_axis_tready & out_en; m_axis_tdata = r_axis_tdata.
- Beat counting:
  - Input beat = s_axis_tvalid & s_axis_tready; in_cnt increments on each input beat.
  - Output beat = m_axis_tvalid & m_axis_tready; out_cnt increments on each output beat.
  - m_axis_tlast = m_axis_tvalid & (out_cnt == rows-1).
- States:
  - IDLE: cfg_start with cfg_rows!=0 latches rows, clears in_cnt/out_cnt/err_tlast, goes to LOAD_W. cfg_start with cfg_rows==0 sets err_cfg and stays IDLE.
  - LOAD_W: moves to STREAM on the input beat where in_cnt==WBEATS-1.
  - STREAM: moves to DRAIN on the input beat where in_cnt==TOTAL-1.
  - DRAIN: moves to DONE on the output beat where out_cnt==rows-1.
  - DONE: done=1 for one cycle, then IDLE.
  - Output beats are accepted in LOAD_W/STREAM, so results produced before input ends are counted. If the output beat with out_cnt==rows-1 occurs in STREAM, out_cnt saturates at rows and DRAIN exits on its next cycle.
- Framing check (err_tlast):
  - Set if tlast=1 on any input beat other than in_cnt==TOTAL-1.
  - Set if tlast=0 on the beat with in_cnt==TOTAL-1.
  - Sequencing is unaffected; the beat is still forwarded.
- cfg_start outside IDLE is ignored.
- cfg_abort in any state: next cycle IDLE, counters cleared, no done pulse, error flags retained. cfg_abort and cfg_start in the same cycle: abort wins.
- err_tlast clears on accepted start; err_cfg clears on any cfg_start with cfg_rows!=0.
- rst mid-frame behaves as abort and also clears the error flags.
- Backpressure: any stall of e_axis_tready or m_axis_tready simply holds the counters; no data is dropped or duplicated.

Test Plan:
- Basic frame: rows=4, e/m ready=1, 7 input beats with tlast on beat 7, engine returns 4 results. Required: states LOAD_W(3)->STREAM(4)->DRAIN, m_axis_tlast on the 4th result only, done pulse, err_tlast=0.
- Early tlast: rows=2, tlast on beat 3 of 5. Required: err_tlast=1, all 5 beats forwarded, done still pulses after 2 results.
- cfg_rows=0: cfg_start pulse. Required: err_cfg=1, busy=0, s_axis_tready stays 0. A later start with rows=1 clears err_cfg.
- Backpressure: rows=3, e_axis_tready toggling 1/0, m_axis_tready low for 10 cycles in DRAIN. Required: exactly 6 input beats and 3 results pass, no loss, done only after the 3rd accepted result.
- Abort: cfg_abort during STREAM after 5 beats. Required: IDLE next cycle, busy=0, no done; next frame with rows=1 completes normally with tlast on its only result.
- Result before input end: rows=1, engine result accepted during STREAM. Required: DRAIN exits one cycle after entry, done pulses.
